// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, Barrett constant helper and FSM encoding for ntt_pwm.
package ntt_pkg;
  localparam int NTT_N = 256;
  localparam int NTT_Q = 8380417;
  localparam int CW = 23;
  function automatic logic [47:0] barrett_mu(input longint unsigned q);
    return 48'((64'd1 << 48) / q);
  endfunction
  localparam logic [47:0] BARRETT_MU = barrett_mu(64'(NTT_Q));
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
endpackage

// File: rtl/ntt_modred.sv
// ntt_modred: Barrett reduction of a 46-bit product plus a modular addend, registered as S3.
module ntt_modred import ntt_pkg::*; #(
  parameter int Q = NTT_Q,
  parameter logic [47:0] MU = BARRETT_MU
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [2*CW-1:0] prod_i,
  input  logic [CW-1:0]   add_i,
  output logic [CW-1:0]   res_o
);
  localparam logic [CW:0] QW = (CW+1)'(Q);
  logic [2*CW-1:0] qt;
  logic [CW:0] r0, r1, r2, s0;
  logic [CW-1:0] res_d, res_q;
  // Quotient estimate is short by at most one, so r0 < 2Q fits in CW+1 bits
  always_comb begin
    qt = (2*CW)'((94'(prod_i) * 94'(MU)) >> 48);
    r0 = (CW+1)'(48'(prod_i) - 48'(qt) * 48'(Q));
    r1 = r0 >= QW ? r0 - QW : r0;
    r2 = r1 >= QW ? r1 - QW : r1;
    s0 = r2 + {1'b0, add_i};
    res_d = s0 >= QW ? CW'(s0 - QW) : s0[CW-1:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) res_q <= '0;
    else if (en_i) res_q <= res_d;
  assign res_o = res_q;
endmodule

// File: rtl/ntt_pwm.sv
// ntt_pwm: pipelined pointwise multiply mod Q (S1 operands, S2 product, S3 Barrett).
// Define NTT_PWM_ACC_EN to add acc_clr and a per-index modular accumulator.
module ntt_pwm import ntt_pkg::*; #(
  parameter int N = NTT_N,
  parameter int Q = NTT_Q
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_data,
`ifdef NTT_PWM_ACC_EN
  input  logic          acc_clr,
`endif
  output logic [7:0]    b_addr,
  input  logic [CW-1:0] b_data,
  output logic          out_valid,
  output logic [CW-1:0] out_data,
  output logic          frame_done,
  output logic          busy
);
  localparam logic [7:0] LAST = 8'(N - 1);
  state_e state_q, state_d;
  logic [7:0] in_cnt_q, in_cnt_d;
  logic in_last, pipe_empty;
  logic v1_q, v2_q, v3_q, last1_q, last2_q, last3_q;
  logic [CW-1:0] a1_q, b1_q, add;
  logic [2*CW-1:0] prod2_q;
  assign in_last = in_cnt_q == LAST;
  assign pipe_empty = !(v1_q || v2_q || v3_q);
  assign b_addr = in_cnt_q;
  assign out_valid = v3_q;
  assign frame_done = v3_q && last3_q;
  assign busy = !pipe_empty || in_cnt_q != '0;
  always_comb begin
    in_cnt_d = !in_valid ? in_cnt_q : in_last ? '0 : in_cnt_q + 8'd1;
    state_d = state_q;
    state_d = state_q == ST_IDLE ? (in_valid ? ST_RUN : ST_IDLE) :
              state_q == ST_RUN  ? (in_valid && in_last ? ST_DRAIN : ST_RUN) :
              in_valid ? ST_RUN : pipe_empty ? ST_IDLE : ST_DRAIN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      in_cnt_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      prod2_q <= '0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        a1_q <= in_data;
        b1_q <= b_data;
        last1_q <= in_last;
      end
      if (v1_q) begin
        prod2_q <= (2*CW)'(a1_q) * (2*CW)'(b1_q);
        last2_q <= last1_q;
      end
      if (v2_q) last3_q <= last2_q;
    end
  end
`ifdef NTT_PWM_ACC_EN
  logic [CW-1:0] acc_q [256];
  logic [7:0] idx1_q, idx2_q, idx3_q;
  logic clr_in, clr_frame_q, clr1_q, clr2_q;
  // acc_clr is sampled on the index-0 beat and applies to the whole frame
  assign clr_in = in_cnt_q == '0 ? acc_clr : clr_frame_q;
  assign add = clr2_q ? '0 : acc_q[idx2_q];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx1_q <= '0;
      idx2_q <= '0;
      idx3_q <= '0;
      clr_frame_q <= 1'b0;
      clr1_q <= 1'b0;
      clr2_q <= 1'b0;
    end else begin
      if (in_valid) begin
        idx1_q <= in_cnt_q;
        clr1_q <= clr_in;
        clr_frame_q <= clr_in;
      end
      if (v1_q) begin
        idx2_q <= idx1_q;
        clr2_q <= clr1_q;
      end
      if (v2_q) idx3_q <= idx2_q;
    end
  end
  always_ff @(posedge clk)
    if (v3_q) acc_q[idx3_q] <= out_data;
`else
  assign add = '0;
`endif
  ntt_modred #(.Q(Q), .MU(barrett_mu(64'(Q)))) u_modred (
    .clk(clk),
    .rst(rst),
    .en_i(v2_q),
    .prod_i(prod2_q),
    .add_i(add),
    .res_o(out_data)
  );
endmodule

// File: tb/tb_ntt_pwm.sv
// tb_ntt_pwm: directed vector table plus burst, mid-frame reset and accumulator sequences.
module tb_ntt_pwm;
  import ntt_pkg::*;
  localparam longint QL = 64'd8380417;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [22:0] in_data = '0, b_data, out_data;
  logic [7:0] b_addr;
  logic out_valid, frame_done, busy;
`ifdef NTT_PWM_ACC_EN
  logic acc_clr = 1'b1;
`endif
  logic [22:0] bmem [256];
  int n_chk = 0, n_fail = 0, cyc = 0, vcnt = 0, dcnt = 0;
  bit mon_en = 1'b0;
  typedef struct {longint want; logic last; int cyc;} exp_t;
  typedef struct {logic [22:0] a; logic [22:0] b; longint want;} vec_t;
  exp_t q[$];
  vec_t vecs[10];

  ntt_pwm dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
`ifdef NTT_PWM_ACC_EN
    .acc_clr(acc_clr),
`endif
    .b_addr(b_addr),
    .b_data(b_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .frame_done(frame_done),
    .busy(busy)
  );

  assign b_data = bmem[b_addr];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, want, cyc);
    end
  endtask

  task automatic expect_beat(input longint want, input logic last);
    exp_t e;
    e.want = want;
    e.last = last;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Scoreboard: every out_valid must match the oldest expected beat, exactly 3 cycles after issue
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) chk("idle_out_valid", longint'(out_valid), 0);
      else if (out_valid) begin
        exp_t e;
        e = q.pop_front();
        vcnt++;
        if (frame_done) dcnt++;
        chk("out_data", out_data, e.want);
        chk("frame_done", frame_done, e.last);
        chk("latency", cyc - e.cyc, 3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_chk);
    $fatal(1);
  end

  initial begin
    logic [22:0] a;
    vecs = '{'{23'd1, 23'd5, 64'd5},
             '{23'd8380416, 23'd8380416, 64'd1},
             '{23'd4194304, 23'd4194304, 64'd6297599},
             '{23'd0, 23'd12345, 64'd0},
             '{23'd8388607, 23'd8388607, 64'd32764},
             '{23'd8380417, 23'd7, 64'd0},
             '{23'd8380418, 23'd3, 64'd3},
             '{23'd2, 23'd3, 64'd6},
             '{23'd1000000, 23'd1000000, 64'd6741475},
             '{23'd8380416, 23'd2, 64'd8380415}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_addr", b_addr, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("vec_b_addr", b_addr, i);
      bmem[i] = vecs[i].b;
      in_data = vecs[i].a;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat1", out_valid, 0);
      @(negedge clk);
      chk("vec_lat2", out_valid, 0);
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[i].want);
      chk("vec_done", frame_done, 0);
      @(negedge clk);
      chk("vec_hold_valid", out_valid, 0);
      chk("vec_hold_data", out_data, vecs[i].want);
    end
    pulse_reset();
    for (int k = 0; k < 256; k++) bmem[k] = 23'((k * 104729 + 11) % 8388608);
    mon_en = 1'b1;
    for (int k = 0; k < 512; k++) begin
      @(posedge clk); #1;
      chk("burst_b_addr", b_addr, k % 256);
      a = 23'((k * 7919 + 3) * 31);
      in_valid = 1'b1;
      in_data = a;
      expect_beat((longint'(a) * longint'(bmem[k % 256])) % QL, (k % 256) == 255);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("burst_count", vcnt, 512);
    chk("burst_frames", dcnt, 2);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = 23'(k + 1);
      expect_beat((longint'(k + 1) * longint'(bmem[k])) % QL, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_b_addr", b_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_b_addr", b_addr, 0);
    bmem[0] = 23'd5;
    in_data = 23'd1;
    in_valid = 1'b1;
    expect_beat(5, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
`ifdef NTT_PWM_ACC_EN
    pulse_reset();
    for (int k = 0; k < 256; k++) bmem[k] = 23'd2;
    for (int k = 0; k < 512; k++) begin
      @(posedge clk); #1;
      acc_clr = k < 256;
      in_valid = 1'b1;
      in_data = 23'd2;
      expect_beat(k < 256 ? 4 : 8, (k % 256) == 255);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr = 1'b1;
    drain();
`endif
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
